serial_wb_master: RTL and testbench

Byte-stream-to-Wishbone bridge that sits directly upstream of the LED/peripheral slaves on the serial Wishbone link. It takes bytes from the UART receiver and parses fixed-format command frames. It issues one Wishbone classic single read or write per frame. Each frame's status byte, plus read data for read frames, goes back to the UART transmitter over a valid/ready handshake.

---
 rtl/serial_wb_master.sv | 222 ++++++++++++++++++++++
 tb/tb_serial_wb_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_wb_master.sv
// -----------------------------------------------------------------------------
// serial_wb_master
//
// Byte-stream to Wishbone classic bridge. Command frames arrive one byte at a
// time from a UART receiver; each complete frame produces exactly one
// Wishbone single read or write. The frame's status byte, followed by four
// read-data bytes for reads, is returned over a valid/ready byte stream.
//
// Frame formats (multi-byte fields big-endian, MSB first):
//   write : 0xA1, A3, A2, A1, A0, D3, D2, D1, D0
//   read  : 0xA2, A3, A2, A1, A0
// Status bytes: 0x55 = ack, 0xE1 = bus error, 0xE2 = timeout.
//
// Optional build macro:
//   WB_TIMEOUT_EN - when defined, a bus cycle with no ack/err is abandoned
//                   after TIMEOUT_CYCLES cycles with status 0xE2. When not
//                   defined, the bridge waits for ack/err indefinitely.
//
// Parameters:
//   ADDR_WIDTH     - Wishbone address width (zero-filled above bit 31,
//                    truncated below 32)
//   TIMEOUT_CYCLES - bus cycles allowed before abort (WB_TIMEOUT_EN only)
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid   received byte and its one-cycle strobe
//   o_tx_data, o_tx_valid   response byte stream
//   i_tx_ready              response byte accepted when valid & ready
//   wb_*                    Wishbone classic master interface
// -----------------------------------------------------------------------------
module serial_wb_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [31:0]           wb_dat_o,
   input  logic [31:0]           wb_dat_i,
   output logic                  wb_we_o,
   output logic [3:0]            wb_sel_o,
   output logic                  wb_stb_o,
   output logic                  wb_cyc_o,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_BUS  = 3'd3,
      S_RESP = 3'd4
   } state_t;

   localparam logic [7:0] CMD_WR = 8'hA1;
   localparam logic [7:0] CMD_RD = 8'hA2;
   localparam logic [7:0] ST_ACK = 8'h55;
   localparam logic [7:0] ST_ERR = 8'hE1;
   localparam logic [7:0] ST_TMO = 8'hE2;

   if (ADDR_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("serial_wb_master: ADDR_WIDTH and TIMEOUT_CYCLES must be >= 1");
   end

   state_t      state;
   state_t      state_nxt;

   // Shared byte counter: field byte index in ADDR/DATA, response byte
   // index in RESP. Cleared whenever a phase completes.
   logic [2:0]  cnt;
   logic        wr_flag;
   logic [31:0] addr_sr;
   logic [31:0] data_sr;
   logic [31:0] rdata;
   logic [7:0]  status;

   logic        is_cmd;
   logic        last_field_byte;
   logic        resp_last;
   logic        tmo_hit;

   assign is_cmd          = (i_rx_data == CMD_WR) || (i_rx_data == CMD_RD);
   assign last_field_byte = i_rx_valid && (cnt == 3'd3);
   // Writes answer with the status byte only; reads add four data bytes.
   assign resp_last       = wr_flag ? (cnt == 3'd0) : (cnt == 3'd4);

`ifdef WB_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt;

   // Counts BUS cycles; held at zero in every other state so it is already
   // clear on entry to BUS. It never needs to pass TMO_LAST because BUS is
   // left on that cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt <= '0;
      end else if (state != S_BUS) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
   assign tmo_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (i_rx_valid && is_cmd)  state_nxt = S_ADDR;
         S_ADDR: if (last_field_byte)       state_nxt = wr_flag ? S_DATA : S_BUS;
         S_DATA: if (last_field_byte)       state_nxt = S_BUS;
         S_BUS:  if (wb_ack_i || wb_err_i || tmo_hit) state_nxt = S_RESP;
         S_RESP: if (i_tx_ready && resp_last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame capture, bus result capture and response sequencing.
   // Bytes arriving in BUS or RESP fall through without effect.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt     <= 3'd0;
         wr_flag <= 1'b0;
         addr_sr <= 32'h0;
         data_sr <= 32'h0;
         rdata   <= 32'h0;
         status  <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_rx_valid && is_cmd) begin
                  wr_flag <= (i_rx_data == CMD_WR);
                  cnt     <= 3'd0;
               end
            end
            S_ADDR: begin
               if (i_rx_valid) begin
                  addr_sr <= {addr_sr[23:0], i_rx_data};
                  cnt     <= (cnt == 3'd3) ? 3'd0 : cnt + 3'd1;
               end
            end
            S_DATA: begin
               if (i_rx_valid) begin
                  data_sr <= {data_sr[23:0], i_rx_data};
                  cnt     <= (cnt == 3'd3) ? 3'd0 : cnt + 3'd1;
               end
            end
            S_BUS: begin
               cnt <= 3'd0;
               // err takes priority over ack; a real response in the final
               // timeout cycle takes priority over the timeout.
               if (wb_err_i) begin
                  status <= ST_ERR;
                  rdata  <= 32'h0;
               end else if (wb_ack_i) begin
                  status <= ST_ACK;
                  rdata  <= wr_flag ? 32'h0 : wb_dat_i;
               end else if (tmo_hit) begin
                  status <= ST_TMO;
                  rdata  <= 32'h0;
               end
            end
            S_RESP: begin
               if (i_tx_ready) begin
                  cnt <= resp_last ? 3'd0 : cnt + 3'd1;
               end
            end
            default: begin
               cnt <= 3'd0;
            end
         endcase
      end
   end

   // Output decode. Bus and stream strobes are pure functions of the state,
   // so an asynchronous reset drops them immediately.
   always_comb begin
      wb_cyc_o   = (state == S_BUS);
      wb_stb_o   = (state == S_BUS);
      wb_we_o    = (state == S_BUS) && wr_flag;
      o_tx_valid = (state == S_RESP);
      o_tx_data  = 8'h00;
      if (state == S_RESP) begin
         case (cnt)
            3'd0:    o_tx_data = status;
            3'd1:    o_tx_data = rdata[31:24];
            3'd2:    o_tx_data = rdata[23:16];
            3'd3:    o_tx_data = rdata[15:8];
            3'd4:    o_tx_data = rdata[7:0];
            default: o_tx_data = 8'h00;
         endcase
      end
   end

   // Address/data registers only change while a frame is being received,
   // so they are stable for the whole bus cycle.
   assign wb_adr_o = ADDR_WIDTH'(addr_sr);
   assign wb_dat_o = data_sr;
   assign wb_sel_o = 4'hF;

endmodule

// File: tb/tb_serial_wb_master.sv
`timescale 1ns/1ps
module tb_serial_wb_master;

`ifdef WB_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1024;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i;
   logic        wb_err_i;

   always #5 i_clk = ~i_clk;

   serial_wb_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_rx_data  (i_rx_data),
      .i_rx_valid (i_rx_valid),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .i_tx_ready (i_tx_ready),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_we_o    (wb_we_o),
      .wb_sel_o   (wb_sel_o),
      .wb_stb_o   (wb_stb_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Expected response bytes for the frame in flight.
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: kind 0 = ack, 1 = err, 2 = ack+err, 3 = no response.
   function automatic void model(input bit wr, input int kind, input logic [31:0] rd);
      logic [7:0]  st;
      logic [31:0] r;
      if (kind == 0)      st = 8'h55;
      else if (kind == 3) st = 8'hE2;
      else                st = 8'hE1;
      r = (st == 8'h55) ? rd : 32'h0;
      exp_q.delete();
      exp_q.push_back(st);
      if (!wr) for (int i = 3; i >= 0; i--) exp_q.push_back(r[8*i +: 8]);
   endfunction

   task automatic noise();
      i_rx_valid = 1'($urandom_range(0, 1));
      i_rx_data  = 8'($urandom);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit is_last);
      i_rx_valid = 1'b0;
      repeat (gap) @(negedge i_clk);
      if (is_last) chk("cyc_before_last", wb_cyc_o, 1'b0);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      @(negedge i_clk);
      i_rx_valid = 1'b0;
   endtask

   task automatic send_frame(input bit wr, input logic [31:0] a, input logic [31:0] d, input int gapmax);
      logic [7:0] fb[$];
      fb.push_back(wr ? 8'hA1 : 8'hA2);
      for (int i = 3; i >= 0; i--) fb.push_back(a[8*i +: 8]);
      if (wr) for (int i = 3; i >= 0; i--) fb.push_back(d[8*i +: 8]);
      foreach (fb[i]) send_byte(fb[i], int'($urandom_range(0, gapmax)), i == fb.size() - 1);
   endtask

   // Entered at the first negedge after the last frame byte was sampled.
   task automatic do_bus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int kind, input int delay);
      chk("cyc_rise", wb_cyc_o, 1'b1);
      chk("stb_rise", wb_stb_o, 1'b1);
      chk("we", wb_we_o, wr);
      chk("adr", wb_adr_o, a);
      chk("sel", wb_sel_o, 4'hF);
      if (wr) chk("wdat", wb_dat_o, d);
      for (int i = 0; i < delay; i++) begin
         noise();
         @(negedge i_clk);
         chk("cyc_hold", wb_cyc_o, 1'b1);
         chk("adr_hold", wb_adr_o, a);
      end
      wb_ack_i = (kind == 0 || kind == 2);
      wb_err_i = (kind == 1 || kind == 2);
      wb_dat_i = rd;
      noise();
      @(negedge i_clk);
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      wb_dat_i   = $urandom;
      i_rx_valid = 1'b0;
      chk("cyc_drop", wb_cyc_o, 1'b0);
      chk("stb_drop", wb_stb_o, 1'b0);
   endtask

   // stall_fixed < 0 picks a random 0..2 cycle stall before each handshake.
   task automatic collect(input int stall_fixed);
      int st;
      for (int k = 0; k < exp_q.size(); k++) begin
         st = (stall_fixed < 0) ? int'($urandom_range(0, 2)) : stall_fixed;
         i_tx_ready = 1'b0;
         for (int s = 0; s < st; s++) begin
            noise();
            chk("tx_valid_stall", o_tx_valid, 1'b1);
            chk("tx_hold", o_tx_data, exp_q[k]);
            @(negedge i_clk);
         end
         chk("tx_valid", o_tx_valid, 1'b1);
         chk("tx_data", o_tx_data, exp_q[k]);
         noise();
         i_tx_ready = 1'b1;
         @(negedge i_clk);
         i_tx_ready = 1'b0;
      end
      i_rx_valid = 1'b0;
      chk("tx_valid_drop", o_tx_valid, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc_cnt;
      int hold;
      i_rst_n    = 1'b0;
      i_rx_data  = 8'h00;
      i_rx_valid = 1'b0;
      i_tx_ready = 1'b0;
      wb_dat_i   = 32'h0;
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("rst_tx_valid", o_tx_valid, 1'b0);
      chk("rst_tx_data", o_tx_data, 8'h00);
      chk("rst_cyc", wb_cyc_o, 1'b0);
      chk("rst_stb", wb_stb_o, 1'b0);
      chk("rst_we", wb_we_o, 1'b0);
      chk("rst_adr", wb_adr_o, 32'h0);
      chk("rst_dat", wb_dat_o, 32'h0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Directed write
      send_frame(1'b1, 32'h4, 32'hC, 0);
      do_bus(1'b1, 32'h4, 32'hC, 32'h0, 0, 1);
      model(1'b1, 0, 32'h0);
      collect(0);

      // Directed read, each response byte held through 3 stalled cycles
      send_frame(1'b0, 32'h0, 32'h0, 0);
      do_bus(1'b0, 32'h0, 32'h0, 32'h3F, 0, 1);
      model(1'b0, 0, 32'h3F);
      collect(3);

      // Bus error on write
      send_frame(1'b1, 32'h10, 32'hDEADBEEF, 1);
      do_bus(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1, 2);
      model(1'b1, 1, 32'h0);
      collect(-1);

      // Garbage then resync on a read
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'hFF, 0, 1'b0);
      chk("garbage_cyc", wb_cyc_o, 1'b0);
      chk("garbage_tx", o_tx_valid, 1'b0);
      send_byte(8'hA2, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h08, 0, 1'b1);
      do_bus(1'b0, 32'h8, 32'h0, 32'hA5C3_0F11, 0, 0);
      model(1'b0, 0, 32'hA5C3_0F11);
      collect(-1);

      // ack and err together on a read: error status, zero data
      send_frame(1'b0, 32'h20, 32'h0, 0);
      do_bus(1'b0, 32'h20, 32'h0, 32'hFFFF_FFFF, 2, 0);
      model(1'b0, 2, 32'hFFFF_FFFF);
      collect(1);

      // Randomized frames, back-to-back or with gaps and garbage prefixes
      for (int t = 0; t < 30; t++) begin
         bit          wr;
         logic [31:0] a, d, rd;
         int          kind, ng;
         logic [7:0]  b;
         wr   = 1'($urandom_range(0, 1));
         a    = $urandom;
         d    = $urandom;
         rd   = $urandom;
         kind = int'($urandom_range(0, 2));
         ng   = int'($urandom_range(0, 2));
         for (int g = 0; g < ng; g++) begin
            b = 8'($urandom);
            if (b == 8'hA1 || b == 8'hA2) b = 8'h3C;
            send_byte(b, int'($urandom_range(0, 1)), 1'b0);
         end
         send_frame(wr, a, d, 2);
         do_bus(wr, a, d, rd, kind, int'($urandom_range(0, 4)));
         model(wr, kind, rd);
         collect(-1);
      end

`ifdef WB_TIMEOUT_EN
      // Read with no slave response: abort after TMO cycles
      send_frame(1'b0, 32'h44, 32'h0, 0);
      cyc_cnt = 0;
      while (wb_cyc_o === 1'b1 && cyc_cnt < 100) begin
         cyc_cnt++;
         @(negedge i_clk);
      end
      chk("tmo_cycles", cyc_cnt, TMO);
      model(1'b0, 3, 32'h0);
      collect(-1);

      // ack in the final timeout cycle beats the timeout
      send_frame(1'b1, 32'h48, 32'h1234, 0);
      do_bus(1'b1, 32'h48, 32'h1234, 32'h0, 0, TMO - 1);
      model(1'b1, 0, 32'h0);
      collect(0);
      hold = 5;
`else
      hold = 1000;
`endif

      // Unanswered read, then reset while the bus cycle is open
      send_frame(1'b0, 32'h80, 32'h0, 0);
      cyc_cnt = 0;
      for (int i = 0; i < hold; i++) begin
         if (wb_cyc_o === 1'b1) cyc_cnt++;
         @(negedge i_clk);
      end
      chk("cyc_held", cyc_cnt, hold);
      #2 i_rst_n = 1'b0;
      #1;
      chk("arst_cyc", wb_cyc_o, 1'b0);
      chk("arst_stb", wb_stb_o, 1'b0);
      chk("arst_tx_valid", o_tx_valid, 1'b0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("post_rst_no_resp", o_tx_valid, 1'b0);
      send_frame(1'b1, 32'h4, 32'h5, 0);
      do_bus(1'b1, 32'h4, 32'h5, 32'h0, 0, 1);
      model(1'b1, 0, 32'h0);
      collect(0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
